// File: rtl/bm_ll_req_arb_pkg.sv
// Shared widths and defaults for the linked-list buffer-request arbiter.
// Holds the pointer width, port-id width, burst default and a clog2 helper.
package bm_ll_req_arb_pkg;

  localparam int BUF_PTR_NBITS       = 10;
  localparam int PORT_ID_NBITS       = 2;
  localparam int BM_LL_ARB_MAX_BURST = 4;

  // Ceiling log2 with a floor of 1, so single-entry ranges still get a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bm_ll_tag_fifo.sv
// Tag FIFO that remembers which requester owns each in-flight lookup.
// The head is read combinationally so the popped owner can be routed immediately.
module bm_ll_tag_fifo
  import bm_ll_req_arb_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 8,
  localparam int AW    = clog2_min1(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [CW-1:0]     o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/bm_ll_req_arb.sv
// Round-robin arbiter sharing the linked-list buffer-request port among requesters,
// with per-port credits, in-order return routing and rc_busy burst throttling.
module bm_ll_req_arb
  import bm_ll_req_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TAG_DEPTH       = 8,
  parameter int MAX_BURST       = BM_LL_ARB_MAX_BURST
) (
  input  logic                               clk,
  input  logic                               srst,
  input  logic [NUM_PORTS-1:0]               port_req_valid,
  input  logic [NUM_PORTS*BUF_PTR_NBITS-1:0] port_req_ptr,
  output logic [NUM_PORTS-1:0]               port_req_ready,
  output logic [NUM_PORTS-1:0]               port_ack_valid,
  output logic [BUF_PTR_NBITS-1:0]           port_ack_ptr,
  output logic                               packet_buf_req,
  output logic [BUF_PTR_NBITS-1:0]           packet_buf_req_ptr,
  input  logic                               packet_ack_buf_valid,
  input  logic [BUF_PTR_NBITS-1:0]           packet_ack_buf_ptr,
  input  logic                               rc_busy,
  output logic                               ack_err
);

  localparam int PID_W     = clog2_min1(NUM_PORTS);
  localparam int CNT_W     = clog2_min1(MAX_OUTSTANDING + 1);
  localparam int BURST_W   = clog2_min1(MAX_BURST + 1);
  localparam int TAG_CNT_W = clog2_min1(TAG_DEPTH) + 1;

  logic [PID_W-1:0]         r_rr_ptr;
  logic [CNT_W-1:0]         r_out_cnt [NUM_PORTS];
  logic [BURST_W-1:0]       r_burst_cnt;
  logic                     r_req;
  logic [BUF_PTR_NBITS-1:0] r_req_ptr;
  logic [NUM_PORTS-1:0]     r_ack_valid;
  logic [BUF_PTR_NBITS-1:0] r_ack_ptr;
  logic                     r_ack_err;

  logic [NUM_PORTS-1:0]     w_elig;
  logic [NUM_PORTS-1:0]     w_grant;
  logic [PID_W-1:0]         w_grant_id;
  logic [BUF_PTR_NBITS-1:0] w_sel_ptr;
  logic                     w_found;
  logic                     w_throttle;
  logic                     w_pop;
  logic [PID_W-1:0]         w_fifo_head;
  logic [TAG_CNT_W-1:0]     w_fifo_count;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [NUM_PORTS-1:0]     w_ack_onehot;
  logic [NUM_PORTS-1:0]     w_cnt_dec;
  logic [CNT_W-1:0]         w_out_cnt_next [NUM_PORTS];

  assign w_throttle = rc_busy & (r_burst_cnt == BURST_W'(MAX_BURST));
  assign w_pop      = packet_ack_buf_valid & ~w_fifo_empty;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    // Fullness is judged before this cycle's pop, so a returning slot is not reused yet.
    assign w_elig[gi] = port_req_valid[gi] & (r_out_cnt[gi] < CNT_W'(MAX_OUTSTANDING)) &
                        ~w_fifo_full & ~w_throttle & ~srst;
    assign w_ack_onehot[gi] = w_pop & (w_fifo_head == PID_W'(gi));
    assign w_cnt_dec[gi]    = r_ack_valid[gi] & (r_out_cnt[gi] != '0);
    assign w_out_cnt_next[gi] =
      ( w_grant[gi] & ~w_cnt_dec[gi]) ? r_out_cnt[gi] + 1'b1 :
      (~w_grant[gi] &  w_cnt_dec[gi]) ? r_out_cnt[gi] - 1'b1 : r_out_cnt[gi];
  end

  always_comb begin
    int idx;
    idx        = 0;
    w_grant    = '0;
    w_grant_id = '0;
    w_sel_ptr  = '0;
    w_found    = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!w_found && w_elig[idx]) begin
        w_found      = 1'b1;
        w_grant[idx] = 1'b1;
        w_grant_id   = PID_W'(idx);
        w_sel_ptr    = port_req_ptr[idx*BUF_PTR_NBITS +: BUF_PTR_NBITS];
      end
    end
  end

  bm_ll_tag_fifo #(
    .DATA_W (PID_W),
    .DEPTH  (TAG_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .srst        (srst),
    .i_push      (w_found),
    .i_push_data (w_grant_id),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_req       <= 1'b0;
      r_req_ptr   <= '0;
      r_ack_valid <= '0;
      r_ack_ptr   <= '0;
      r_ack_err   <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) r_out_cnt[i] <= '0;
    end else begin
      if (w_found)
        r_rr_ptr <= (w_grant_id == PID_W'(NUM_PORTS - 1)) ? '0 : w_grant_id + 1'b1;
      // Counts the run of issue cycles including the one being registered now,
      // which makes the forced gap land right after MAX_BURST issues.
      if (w_found)
        r_burst_cnt <= (r_burst_cnt == BURST_W'(MAX_BURST)) ? r_burst_cnt : r_burst_cnt + 1'b1;
      else
        r_burst_cnt <= '0;
      r_req       <= w_found;
      r_req_ptr   <= w_found ? w_sel_ptr : '0;
      r_ack_valid <= w_ack_onehot;
      r_ack_ptr   <= w_pop ? packet_ack_buf_ptr : '0;
      if (packet_ack_buf_valid & w_fifo_empty) r_ack_err <= 1'b1;
      r_out_cnt   <= w_out_cnt_next;
    end
  end

  assign port_req_ready     = w_grant;
  assign packet_buf_req     = r_req;
  assign packet_buf_req_ptr = r_req_ptr;
  assign port_ack_valid     = r_ack_valid;
  assign port_ack_ptr       = r_ack_ptr;
  assign ack_err            = r_ack_err;

endmodule

// File: tb/tb_bm_ll_req_arb.sv
// Scoreboard bench for bm_ll_req_arb: a background monitor checks issues and returns
// against queued expectations while per-scenario tasks check timing inline.
module tb_bm_ll_req_arb;
  import bm_ll_req_arb_pkg::*;

  localparam int NP = 4;
  localparam int W  = BUF_PTR_NBITS;

  logic            clk = 1'b0;
  logic            srst;
  logic [NP-1:0]   port_req_valid;
  logic [NP*W-1:0] port_req_ptr;
  logic [NP-1:0]   port_req_ready;
  logic [NP-1:0]   port_ack_valid;
  logic [W-1:0]    port_ack_ptr;
  logic            packet_buf_req;
  logic [W-1:0]    packet_buf_req_ptr;
  logic            packet_ack_buf_valid;
  logic [W-1:0]    packet_ack_buf_ptr;
  logic            rc_busy;
  logic            ack_err;

  bm_ll_req_arb #(
    .NUM_PORTS(NP), .MAX_OUTSTANDING(2), .TAG_DEPTH(8), .MAX_BURST(4)
  ) dut (
    .clk                  (clk),
    .srst                 (srst),
    .port_req_valid       (port_req_valid),
    .port_req_ptr         (port_req_ptr),
    .port_req_ready       (port_req_ready),
    .port_ack_valid       (port_ack_valid),
    .port_ack_ptr         (port_ack_ptr),
    .packet_buf_req       (packet_buf_req),
    .packet_buf_req_ptr   (packet_buf_req_ptr),
    .packet_ack_buf_valid (packet_ack_buf_valid),
    .packet_ack_buf_ptr   (packet_ack_buf_ptr),
    .rc_busy              (rc_busy),
    .ack_err              (ack_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat   = 4;
  bit resp_en = 1'b0;

  logic [W-1:0] exp_issue[$];
  int           exp_ret_port[$];
  logic [W-1:0] pend_ptr[$];
  int           pend_due[$];
  int           exp_ack_port[$];
  logic [W-1:0] exp_ack_ptr[$];
  int           grant_log[$];
  bit           req_log[$];

  logic [W-1:0] mon_e;
  int           mon_p;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: consumes expectations when the DUT issues or returns, records new grants.
  initial forever begin
    @(negedge clk);
    if (!srst) begin
      if (packet_buf_req) begin
        n_cmp++;
        if (exp_issue.size() == 0) begin
          n_bad++;
          $display("FAIL issue_unexpected: got req ptr %h, required no request", packet_buf_req_ptr);
        end else begin
          mon_e = exp_issue.pop_front();
          if (packet_buf_req_ptr !== mon_e) begin
            n_bad++;
            $display("FAIL issue_ptr: got %h, required %h", packet_buf_req_ptr, mon_e);
          end
        end
        pend_ptr.push_back(packet_buf_req_ptr);
        pend_due.push_back(cyc + lat);
      end
      req_log.push_back(packet_buf_req);
      if (port_ack_valid !== '0) begin
        n_cmp++;
        if (exp_ack_port.size() == 0) begin
          n_bad++;
          $display("FAIL ack_unexpected: got port_ack_valid %b, required none", port_ack_valid);
        end else begin
          mon_p = exp_ack_port.pop_front();
          mon_e = exp_ack_ptr.pop_front();
          if (port_ack_valid !== (NP'(1) << mon_p) || port_ack_ptr !== mon_e) begin
            n_bad++;
            $display("FAIL ack_route: got valid %b ptr %h, required valid %b ptr %h",
                     port_ack_valid, port_ack_ptr, NP'(1) << mon_p, mon_e);
          end
        end
      end
      if ((port_req_ready & port_req_valid) != '0) begin
        n_cmp++;
        if (!$onehot(port_req_ready)) begin
          n_bad++;
          $display("FAIL grant_onehot: got ready %b, required one-hot", port_req_ready);
        end
        for (int p = 0; p < NP; p++) begin
          if (port_req_ready[p]) begin
            exp_issue.push_back(port_req_ptr[p*W +: W]);
            exp_ret_port.push_back(p);
            grant_log.push_back(p);
          end
        end
      end
    end
  end

  task automatic fire_ack();
    logic [W-1:0] p;
    p = pend_ptr.pop_front();
    void'(pend_due.pop_front());
    packet_ack_buf_valid = 1'b1;
    packet_ack_buf_ptr   = p + 10'h014;
    if (exp_ret_port.size() > 0) begin
      exp_ack_port.push_back(exp_ret_port.pop_front());
      exp_ack_ptr.push_back(p + 10'h014);
    end
  endtask

  // Linked-list model: answers each issued pointer with ptr+0x14 after lat cycles.
  initial forever begin
    @(posedge clk);
    #2;
    if (resp_en) begin
      if (pend_ptr.size() > 0 && cyc >= pend_due[0]) fire_ack();
      else packet_ack_buf_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_queues();
    exp_issue.delete();
    exp_ret_port.delete();
    pend_ptr.delete();
    pend_due.delete();
    exp_ack_port.delete();
    exp_ack_ptr.delete();
  endtask

  task automatic do_reset();
    resp_en = 1'b0;
    packet_ack_buf_valid = 1'b0;
    rc_busy = 1'b0;
    srst = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({port_req_ready, port_ack_valid, port_ack_ptr, packet_buf_req, packet_buf_req_ptr, ack_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ready %b ackv %b ackp %h req %b reqp %h err %b, required all 0",
               port_req_ready, port_ack_valid, port_ack_ptr, packet_buf_req, packet_buf_req_ptr, ack_err);
    end
    step();
    step();
    flush_queues();
    srst = 1'b0;
  endtask

  task automatic drain_check(input string name);
    resp_en = 1'b1;
    repeat (14) step();
    n_cmp++;
    if (exp_issue.size() + exp_ret_port.size() + pend_ptr.size() + exp_ack_port.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d issue/%0d tag/%0d pending/%0d ack left, required 0", name,
               exp_issue.size(), exp_ret_port.size(), pend_ptr.size(), exp_ack_port.size());
    end
  endtask

  task automatic test_reset();
    port_req_valid = '1;
    do_reset();
    port_req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    port_req_ptr[2*W +: W] = 10'h013;
    step();
    port_req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (port_req_ready !== 4'b0100) begin
      n_bad++; $display("FAIL single_ready: got %b, required 0100", port_req_ready);
    end
    step();
    port_req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (packet_buf_req !== 1'b1 || packet_buf_req_ptr !== 10'h013) begin
      n_bad++; $display("FAIL single_issue: got req %b ptr %h, required 1 013", packet_buf_req, packet_buf_req_ptr);
    end
    step();
    fire_ack();
    @(negedge clk);
    n_cmp++;
    if (port_ack_valid !== 4'b0000) begin
      n_bad++; $display("FAIL single_ack_early: got %b, required 0000", port_ack_valid);
    end
    step();
    packet_ack_buf_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (port_ack_valid !== 4'b0100 || port_ack_ptr !== 10'h027) begin
      n_bad++; $display("FAIL single_ack: got %b %h, required 0100 027", port_ack_valid, port_ack_ptr);
    end
    drain_check("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    lat = 4;
    resp_en = 1'b1;
    for (int p = 0; p < NP; p++) port_req_ptr[p*W +: W] = W'(10'h100 + p * 16);
    grant_log.delete();
    step();
    port_req_valid = '1;
    repeat (40) step();
    port_req_valid = '0;
    n_cmp++;
    if (grant_log.size() != 40) begin
      n_bad++; $display("FAIL rr_grant_count: got %0d, required 40", grant_log.size());
    end
    for (int i = 0; i < grant_log.size(); i++) begin
      n_cmp++;
      if (grant_log[i] != i % NP) begin
        n_bad++; $display("FAIL rr_order[%0d]: got port %0d, required %0d", i, grant_log[i], i % NP);
      end
    end
    drain_check("rr");
  endtask

  task automatic test_credit();
    do_reset();
    port_req_ptr[1*W +: W] = 10'h055;
    grant_log.delete();
    step();
    port_req_valid = 4'b0010;
    repeat (6) step();
    @(negedge clk);
    n_cmp++;
    if (port_req_ready !== 4'b0000 || grant_log.size() != 2) begin
      n_bad++; $display("FAIL credit_limit: got ready %b grants %0d, required 0000 2", port_req_ready, grant_log.size());
    end
    step();
    fire_ack();
    @(negedge clk);
    n_cmp++;
    if (port_req_ready !== 4'b0000) begin
      n_bad++; $display("FAIL credit_hold: got %b, required 0000", port_req_ready);
    end
    step();
    packet_ack_buf_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (port_ack_valid !== 4'b0010 || port_req_ready !== 4'b0000) begin
      n_bad++; $display("FAIL credit_return: got ackv %b ready %b, required 0010 0000", port_ack_valid, port_req_ready);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (port_req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL credit_regrant: got %b, required 0010", port_req_ready);
    end
    step();
    port_req_valid = '0;
    drain_check("credit");
    n_cmp++;
    if (grant_log.size() != 3) begin
      n_bad++; $display("FAIL credit_total: got %0d grants, required 3", grant_log.size());
    end
  endtask

  task automatic test_throttle();
    do_reset();
    lat = 4;
    resp_en = 1'b1;
    rc_busy = 1'b1;
    for (int p = 0; p < NP; p++) port_req_ptr[p*W +: W] = W'(10'h200 + p);
    step();
    req_log.delete();
    port_req_valid = '1;
    repeat (26) step();
    port_req_valid = '0;
    rc_busy = 1'b0;
    for (int j = 1; j <= 25; j++) begin
      n_cmp++;
      if (req_log[j] != (((j - 1) % 5) != 4)) begin
        n_bad++; $display("FAIL throttle_slot[%0d]: got req %0d, required %0d", j, req_log[j], ((j - 1) % 5) != 4);
      end
    end
    drain_check("throttle");
  endtask

  task automatic test_oob_and_reset();
    do_reset();
    step();
    packet_ack_buf_valid = 1'b1;
    packet_ack_buf_ptr = 10'h3ff;
    step();
    packet_ack_buf_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (port_ack_valid !== 4'b0000 || ack_err !== 1'b1) begin
      n_bad++; $display("FAIL oob_ack: got ackv %b err %b, required 0000 1", port_ack_valid, ack_err);
    end
    lat = 4;
    resp_en = 1'b1;
    for (int p = 0; p < NP; p++) port_req_ptr[p*W +: W] = W'(10'h300 + p);
    repeat (3) step();
    port_req_valid = '1;
    repeat (10) step();
    @(negedge clk);
    n_cmp++;
    if (ack_err !== 1'b1) begin
      n_bad++; $display("FAIL oob_sticky: got %b, required 1", ack_err);
    end
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (port_req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL reset_rr_ptr: got %b, required 0001", port_req_ready);
    end
    step();
    port_req_valid = '0;
    drain_check("oob");
  endtask

  task automatic test_same_cycle();
    do_reset();
    port_req_ptr[0 +: W] = 10'h0aa;
    step();
    port_req_valid = 4'b0001;
    step();
    port_req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (dut.r_out_cnt[0] !== 2'd1 || dut.w_fifo_count !== 4'd1) begin
      n_bad++; $display("FAIL same_setup: got cnt %0d fifo %0d, required 1 1", dut.r_out_cnt[0], dut.w_fifo_count);
    end
    step();
    port_req_valid = 4'b0001;
    fire_ack();
    @(negedge clk);
    n_cmp++;
    if (port_req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL same_push_pop_grant: got %b, required 0001", port_req_ready);
    end
    step();
    port_req_valid = '0;
    packet_ack_buf_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut.w_fifo_count !== 4'd1 || port_ack_valid !== 4'b0001) begin
      n_bad++; $display("FAIL same_fifo_occ: got fifo %0d ackv %b, required 1 0001", dut.w_fifo_count, port_ack_valid);
    end
    step();
    fire_ack();
    @(negedge clk);
    n_cmp++;
    if (dut.r_out_cnt[0] !== 2'd1) begin
      n_bad++; $display("FAIL same_cnt_mid: got %0d, required 1", dut.r_out_cnt[0]);
    end
    step();
    packet_ack_buf_valid = 1'b0;
    port_req_valid = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (port_ack_valid !== 4'b0001 || port_req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL same_cycle_both: got ackv %b ready %b, required 0001 0001", port_ack_valid, port_req_ready);
    end
    step();
    port_req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (dut.r_out_cnt[0] !== 2'd1 || dut.w_fifo_count !== 4'd1) begin
      n_bad++; $display("FAIL same_cnt_hold: got cnt %0d fifo %0d, required 1 1", dut.r_out_cnt[0], dut.w_fifo_count);
    end
    drain_check("same");
  endtask

  initial begin
    srst = 1'b1;
    port_req_valid = '0;
    port_req_ptr = '0;
    packet_ack_buf_valid = 1'b0;
    packet_ack_buf_ptr = '0;
    rc_busy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_credit();
    test_throttle();
    test_oob_and_reset();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units, required completion");
    $fatal(1, "timeout");
  end

endmodule
